// File: rtl/pipe_pkg.sv
// Shared widths and constants for the pipeline stage buffer.
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 10;
  localparam int CNT_W  = 16;

  // Control word of a bubble: every control line deasserted.
  localparam logic [CTRL_W-1:0] CTRL_NOP = {CTRL_W{1'b0}};

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Upstream/downstream valid-ready bus of one pipeline stage buffer.
interface pipe_stage_buf_if #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int CTRL_W = pipe_pkg::CTRL_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );

endinterface

// File: rtl/pipe_stage_buf_sat_cnt.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module pipe_sat_cnt #(
  parameter int CNT_W = pipe_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_sat;

  assign w_sat = &r_cnt;
  assign o_cnt = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_inc && !w_sat) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Registered pipeline stage buffer with flush, bubble insertion and stall counter.
// Define PIPE_SKID_EN for a one-entry skid register and a fully registered in_ready.
module pipe_stage_buf #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int CNT_W  = pipe_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  pipe_stage_buf_if.slave   bus,
  output logic [CNT_W-1:0]  stall_cnt
);
  import pipe_pkg::*;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic              w_stall;
  logic              w_main_free;

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ctrl  = r_out_ctrl;
  assign w_stall       = r_out_valid && !bus.out_ready;
  assign w_main_free   = !r_out_valid || bus.out_ready;

`ifdef PIPE_SKID_EN
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  assign bus.in_ready = !r_skid_valid;

  // The skid entry refills the main register ahead of new input, keeping order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= {DATA_W{1'b0}};
      r_out_ctrl   <= CTRL_W'(CTRL_NOP);
      r_skid_valid <= 1'b0;
      r_skid_data  <= {DATA_W{1'b0}};
      r_skid_ctrl  <= CTRL_W'(CTRL_NOP);
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_out_ctrl   <= CTRL_W'(CTRL_NOP);
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_out_ctrl   <= r_skid_ctrl;
        r_skid_valid <= 1'b0;
      end else if (bus.in_valid) begin
        r_out_valid <= 1'b1;
        r_out_data  <= bus.in_data;
        r_out_ctrl  <= bus.in_ctrl;
      end else begin
        r_out_valid <= 1'b0;
        r_out_ctrl  <= CTRL_W'(CTRL_NOP);
      end
    end else if (bus.in_valid && !r_skid_valid) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= bus.in_data;
      r_skid_ctrl  <= bus.in_ctrl;
    end
  end
`else
  logic w_load;

  assign bus.in_ready = w_main_free;
  assign w_load       = bus.in_valid && w_main_free;

  // Single holding register; a drained stage without new input becomes a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= {DATA_W{1'b0}};
      r_out_ctrl  <= CTRL_W'(CTRL_NOP);
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_out_ctrl  <= CTRL_W'(CTRL_NOP);
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= bus.in_data;
      r_out_ctrl  <= bus.in_ctrl;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
      r_out_ctrl  <= CTRL_W'(CTRL_NOP);
    end
  end
`endif

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_stall),
    .o_cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: vector table, hand sequences and random vs. queue model.
module tb_pipe_stage_buf;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        flush2;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt2;

  pipe_stage_buf_if #(.DATA_W(32), .CTRL_W(10)) bus ();
  pipe_stage_buf_if #(.DATA_W(32), .CTRL_W(10)) b2 ();

  pipe_stage_buf #(.DATA_W(32), .CTRL_W(10), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .stall_cnt(stall_cnt)
  );

  pipe_stage_buf #(.DATA_W(32), .CTRL_W(10), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush2), .bus(b2), .stall_cnt(stall_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: the stage is an ordered queue of beats with a fixed capacity.
  typedef struct packed {
    logic [31:0] d;
    logic [9:0]  c;
  } beat_t;

  beat_t       mq[$];
  logic [31:0] m_last;
  int unsigned m_stall;
  localparam int unsigned STALL_MAX = 65535;

  function automatic logic m_in_ready(input logic r);
`ifdef PIPE_SKID_EN
    return mq.size() < 2;
`else
    return (mq.size() == 0) || r;
`endif
  endfunction

  task automatic m_reset();
    mq.delete();
    m_last  = 32'h0;
    m_stall = 0;
  endtask

  task automatic m_edge();
    logic acc;
    acc = bus.in_valid && m_in_ready(bus.out_ready);
    if (mq.size() > 0 && !bus.out_ready && m_stall < STALL_MAX) m_stall++;
    if (flush) begin
      mq.delete();
    end else begin
      if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
      if (acc) mq.push_back('{d: bus.in_data, c: bus.in_ctrl});
    end
    if (mq.size() > 0) m_last = mq[0].d;
  endtask

  task automatic m_check(input string tag);
    chk({tag, ".valid"}, bus.out_valid, mq.size() > 0);
    chk({tag, ".data"}, bus.out_data, m_last);
    chk({tag, ".ctrl"}, bus.out_ctrl, (mq.size() > 0) ? mq[0].c : 10'h0);
    chk({tag, ".stall"}, stall_cnt, m_stall);
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [9:0] c,
                       input logic r, input logic f);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_ctrl   = c;
    bus.out_ready = r;
    flush         = f;
  endtask

  task automatic edge_check(input string tag);
    m_edge();
    @(posedge clk);
    #1;
    m_check(tag);
  endtask

  // Called one time unit after a rising edge, inputs already driven.
  task automatic tick(input string tag);
    #2;
    chk({tag, ".in_ready"}, bus.in_ready, m_in_ready(bus.out_ready));
    edge_check(tag);
  endtask

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [9:0]  c;
    logic        r;
    logic        f;
    logic        ev;
    logic [31:0] ed;
    logic [9:0]  ec;
  } vec_t;

  vec_t        tbl[14];
  logic [31:0] got[$];
  logic        rp[12];
  int unsigned stall_base;
  int          src_idx;

  initial begin
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 32'h100 + 32'(i), 10'(i + 1), 1'b1, 1'b0, 1'b1, 32'h100 + 32'(i), 10'(i + 1)};
    tbl[8]  = '{1'b0, 32'h0,   10'h000, 1'b1, 1'b0, 1'b0, 32'h107, 10'h000};
    tbl[9]  = '{1'b1, 32'h200, 10'h3FF, 1'b1, 1'b0, 1'b1, 32'h200, 10'h3FF};
    tbl[10] = '{1'b1, 32'h201, 10'h155, 1'b0, 1'b1, 1'b0, 32'h200, 10'h000};
    tbl[11] = '{1'b0, 32'h0,   10'h000, 1'b1, 1'b0, 1'b0, 32'h200, 10'h000};
    tbl[12] = '{1'b1, 32'h300, 10'h001, 1'b0, 1'b0, 1'b1, 32'h300, 10'h001};
    tbl[13] = '{1'b1, 32'h301, 10'h002, 1'b1, 1'b1, 1'b0, 32'h300, 10'h000};

    rst    = 1'b1;
    flush2 = 1'b0;
    drive(1'b0, 32'h0, 10'h0, 1'b1, 1'b0);
    b2.in_valid  = 1'b0;
    b2.in_data   = 32'h0;
    b2.in_ctrl   = 10'h0;
    b2.out_ready = 1'b1;
    m_reset();

    #2;
    chk("rst.valid", bus.out_valid, 1'b0);
    chk("rst.ctrl", bus.out_ctrl, 10'h0);
    chk("rst.data", bus.out_data, 32'h0);
    chk("rst.stall", stall_cnt, 16'h0);
    chk("rst.in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Saturation on the 4-bit counter instance.
    b2.in_valid  = 1'b1;
    b2.in_data   = 32'hABC;
    b2.in_ctrl   = 10'h001;
    b2.out_ready = 1'b0;
    @(posedge clk);
    #1;
    b2.in_valid = 1'b0;
    chk("sat.loaded", b2.out_valid, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sat.cnt%0d", k), stall_cnt2, (k < 15) ? k : 15);
    end
    b2.out_ready = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].r, tbl[i].f);
      tick($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.exp_valid", i), bus.out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d.exp_data", i), bus.out_data, tbl[i].ed);
      chk($sformatf("tbl%0d.exp_ctrl", i), bus.out_ctrl, tbl[i].ec);
    end
    drive(1'b0, 32'h0, 10'h0, 1'b1, 1'b0);
    tick("drain0");
    tick("drain1");

`ifdef PIPE_SKID_EN
    // Backpressure: three stall cycles while a source offers six beats.
    rp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    stall_base = m_stall;
    src_idx = 0;
    got.delete();
    for (int c = 0; c < 12; c++) begin
      logic hs_in;
      drive(src_idx < 6, 32'h400 + 32'(src_idx), 10'(src_idx + 1), rp[c], 1'b0);
      #2;
      chk($sformatf("bp%0d.in_ready", c), bus.in_ready, m_in_ready(bus.out_ready));
      hs_in = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
      edge_check($sformatf("bp%0d", c));
      if (hs_in) src_idx++;
      if (c == 1) chk("bp.in_ready_full", bus.in_ready, 1'b0);
      if (c == 3) chk("bp.stall3", stall_cnt, stall_base + 3);
    end
    chk("bp.count", got.size(), 6);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("bp.order%0d", i), got[i], 32'h400 + 32'(i));
`else
    // Combinational in_ready follows out_ready within the cycle.
    drive(1'b1, 32'h700, 10'h005, 1'b1, 1'b0);
    tick("ns.fill");
    drive(1'b1, 32'h701, 10'h006, 1'b0, 1'b0);
    #1;
    chk("ns.in_ready_stalled", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    #1;
    chk("ns.in_ready_free", bus.in_ready, 1'b1);
    edge_check("ns.pass");
    chk("ns.next_data", bus.out_data, 32'h701);
`endif
    drive(1'b0, 32'h0, 10'h0, 1'b1, 1'b0);
    tick("idle");

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom, 10'($urandom), $urandom_range(0, 9) < 6,
            $urandom_range(0, 19) == 0);
      tick($sformatf("rnd%0d", i));
    end

    // Asynchronous reset in the middle of a stalled transfer.
    drive(1'b1, 32'h500, 10'h0AA, 1'b1, 1'b0);
    tick("pre_rst0");
    drive(1'b1, 32'h501, 10'h0AB, 1'b0, 1'b0);
    tick("pre_rst1");
    tick("pre_rst2");
    #3;
    rst = 1'b1;
    #1;
    chk("arst.valid", bus.out_valid, 1'b0);
    chk("arst.ctrl", bus.out_ctrl, 10'h0);
    chk("arst.data", bus.out_data, 32'h0);
    chk("arst.stall", stall_cnt, 16'h0);
    chk("arst.in_ready", bus.in_ready, 1'b1);
    #1;
    rst = 1'b0;
    m_reset();
    drive(1'b1, 32'h600, 10'h00F, 1'b1, 1'b0);
    #1;
    tick("post_rst");
    chk("post_rst.first", bus.out_data, 32'h600);
    chk("post_rst.valid", bus.out_valid, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
